// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16-entry register file.
// Two requesters (ALU result path, memory load path) share the single
// register-file write port through a round-robin arbiter. The winning write
// is registered and driven on wr_* for exactly one cycle. A 16-bit busy
// scoreboard tracks destination registers reserved by the issue stage and
// not yet written back.
//
// Handshake (both requesters): ready is combinational on the valids and the
// last grant, and is only ever high together with its own valid. A transfer
// happens when valid and ready are both 1 at a rising edge. At most one
// requester is ready in any cycle. A requester that is not granted keeps
// valid/dest/data stable until it is.
module regfile_wb_arbiter #(
  parameter int DATA_W         = 32,
  parameter bit REG0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [3:0]        alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [3:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rsv_en,
  input  logic [3:0]        rsv_reg,
  output logic [15:0]       busy,
  output logic              rsv_waw,
  output logic              wr_en,
  output logic [3:0]        wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       wr_onehot
);

  // Which requester won the most recent transfer; the other one has priority
  // the next time both are valid.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e              last_grant_q, last_grant_d;
  logic                wr_en_q, wr_en_d;
  logic [3:0]          wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [15:0]         busy_q, busy_d;
  logic                rsv_waw_q, rsv_waw_d;

  logic                grant_alu;
  logic                grant_mem;
  logic                xfer;
  logic [3:0]          xfer_dest;
  logic [DATA_W-1:0]   xfer_data;
  logic                xfer_writes;
  logic                rsv_allowed;
  logic                rsv_clear_hit;

  // Round-robin arbitration; nothing is granted while reset is asserted.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (reset_n) begin
      if (alu_valid && (!mem_valid || (last_grant_q == GRANT_MEM))) begin
        grant_alu = 1'b1;
      end else if (mem_valid) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Select the transferring request and decide whether it reaches the file.
  // Writes to a hardwired register 0 are accepted but never strobed.
  always_comb begin
    xfer         = grant_alu || grant_mem;
    xfer_dest    = grant_alu ? alu_dest : mem_dest;
    xfer_data    = grant_alu ? alu_data : mem_data;
    xfer_writes  = xfer && !(REG0_HARDWIRED && (xfer_dest == 4'd0));
    last_grant_d = last_grant_q;
    if (grant_alu) begin
      last_grant_d = GRANT_ALU;
    end else if (grant_mem) begin
      last_grant_d = GRANT_MEM;
    end
  end

  // Next state of the registered write port; address/data hold when idle.
  always_comb begin
    wr_en_d   = xfer_writes;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (xfer_writes) begin
      wr_reg_d  = xfer_dest;
      wr_data_d = xfer_data;
    end
  end

  // Scoreboard: clear on transfer first, then apply the reservation so that
  // a same-edge reserve of the register being written leaves it busy for
  // the new producer. That case is not a WAW hazard.
  always_comb begin
    rsv_allowed   = rsv_en && !(REG0_HARDWIRED && (rsv_reg == 4'd0));
    rsv_clear_hit = xfer && (xfer_dest == rsv_reg);
    busy_d        = busy_q;
    if (xfer) begin
      busy_d[xfer_dest] = 1'b0;
    end
    if (rsv_allowed) begin
      busy_d[rsv_reg] = 1'b1;
    end
    rsv_waw_d = rsv_allowed && busy_q[rsv_reg] && !rsv_clear_hit;
  end

  // State registers; async reset drops any accepted-but-undriven write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_MEM;
      wr_en_q      <= 1'b0;
      wr_reg_q     <= 4'd0;
      wr_data_q    <= '0;
      busy_q       <= 16'h0000;
      rsv_waw_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      rsv_waw_q    <= rsv_waw_d;
    end
  end

  // One-hot write enable decoded from the registered address, gated by wr_en.
  always_comb begin
    wr_onehot = 16'h0000;
    if (wr_en_q) begin
      wr_onehot[wr_reg_q] = 1'b1;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign rsv_waw = rsv_waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the write-back rules.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic              alu_valid;
  logic              alu_ready;
  logic [3:0]        alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [3:0]        mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              rsv_en;
  logic [3:0]        rsv_reg;
  logic [15:0]       busy;
  logic              rsv_waw;
  logic              wr_en;
  logic [3:0]        wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       wr_onehot;

  int checks   = 0;
  int failures = 0;

  // expected register-file writes, {reg, data}
  logic [DATA_W+3:0] exp_q[$];

  regfile_wb_arbiter #(.DATA_W(DATA_W), .REG0_HARDWIRED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy(busy), .rsv_waw(rsv_waw),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_onehot(wr_onehot)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dest = 4'd0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = 4'd0; mem_data = '0;
    rsv_en = 1'b0; rsv_reg = 4'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_dest = 4'd2; alu_data = 32'h0000_00A5;
    #3;
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL rst_alu_ready: got %0b expected 0", alu_ready); end
    checks++; if (wr_en !== 1'b0 || busy !== 16'h0 || rsv_waw !== 1'b0) begin failures++; $display("FAIL rst_state: got wr_en=%0b busy=%04h waw=%0b expected 0/0000/0", wr_en, busy, rsv_waw); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    rsv_en = 1'b1; rsv_reg = 4'd6;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL rst_first_grant: got %0b expected 1", alu_ready); end
    edge_wait();
    alu_valid = 1'b0; rsv_en = 1'b0;
    checks++; if (busy !== 16'h0040 || wr_en !== 1'b1 || wr_onehot !== 16'h0004) begin failures++; $display("FAIL rst_pre: got busy=%04h wr_en=%0b oh=%04h expected 0040/1/0004", busy, wr_en, wr_onehot); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 16'h0 || wr_en !== 1'b0 || wr_onehot !== 16'h0) begin failures++; $display("FAIL rst_async: got busy=%04h wr_en=%0b oh=%04h expected 0000/0/0000", busy, wr_en, wr_onehot); end
    checks++; if (wr_reg !== 4'd0 || wr_data !== '0) begin failures++; $display("FAIL rst_wr_regs: got reg=%0d data=%08h expected 0/0", wr_reg, wr_data); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_arbitration();
    apply_reset();
    alu_valid = 1'b1; alu_dest = 4'd5; alu_data = 32'hDEADBEEF;
    mem_valid = 1'b1; mem_dest = 4'd9; mem_data = 32'h12345678;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL arb_first: got alu=%0b mem=%0b expected 1/0", alu_ready, mem_ready); end
    edge_wait();
    checks++; if (wr_en !== 1'b1 || wr_reg !== 4'd5 || wr_onehot !== 16'h0020 || wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL arb_alu_wr: got en=%0b reg=%0d oh=%04h data=%08h expected 1/5/0020/deadbeef", wr_en, wr_reg, wr_onehot, wr_data); end
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin failures++; $display("FAIL arb_second: got alu=%0b mem=%0b expected 0/1", alu_ready, mem_ready); end
    edge_wait();
    checks++; if (wr_en !== 1'b1 || wr_reg !== 4'd9 || wr_onehot !== 16'h0200 || wr_data !== 32'h12345678) begin failures++; $display("FAIL arb_mem_wr: got en=%0b reg=%0d oh=%04h data=%08h expected 1/9/0200/12345678", wr_en, wr_reg, wr_onehot, wr_data); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (alu_ready !== ((i % 2) == 0) || mem_ready !== ((i % 2) == 1)) begin
        failures++; $display("FAIL arb_alternate_%0d: got alu=%0b mem=%0b expected %0b/%0b", i, alu_ready, mem_ready, (i % 2) == 0, (i % 2) == 1);
      end
      edge_wait();
    end
    idle_inputs();
    edge_wait();
    checks++; if (wr_en !== 1'b0 || wr_onehot !== 16'h0) begin failures++; $display("FAIL arb_idle: got en=%0b oh=%04h expected 0/0000", wr_en, wr_onehot); end
  endtask

  task automatic test_scoreboard();
    apply_reset();
    rsv_en = 1'b1; rsv_reg = 4'd3;
    edge_wait();
    rsv_en = 1'b0;
    checks++; if (busy !== 16'h0008) begin failures++; $display("FAIL sb_set: got %04h expected 0008", busy); end
    mem_valid = 1'b1; mem_dest = 4'd3; mem_data = 32'hCAFE0003;
    #1;
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL sb_mem_ready: got %0b expected 1", mem_ready); end
    edge_wait();
    mem_valid = 1'b0;
    checks++; if (busy !== 16'h0000 || wr_en !== 1'b1 || wr_reg !== 4'd3) begin failures++; $display("FAIL sb_clear: got busy=%04h en=%0b reg=%0d expected 0000/1/3", busy, wr_en, wr_reg); end
  endtask

  task automatic test_set_clear_same_edge();
    apply_reset();
    rsv_en = 1'b1; rsv_reg = 4'd7;
    edge_wait();
    alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 32'h77777777;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL sc_alu_ready: got %0b expected 1", alu_ready); end
    edge_wait();
    alu_valid = 1'b0;
    checks++; if (busy !== 16'h0080 || rsv_waw !== 1'b0 || wr_en !== 1'b1) begin failures++; $display("FAIL sc_same_edge: got busy=%04h waw=%0b en=%0b expected 0080/0/1", busy, rsv_waw, wr_en); end
    edge_wait();
    rsv_en = 1'b0;
    checks++; if (rsv_waw !== 1'b1 || busy !== 16'h0080) begin failures++; $display("FAIL sc_waw_pulse: got waw=%0b busy=%04h expected 1/0080", rsv_waw, busy); end
    edge_wait();
    checks++; if (rsv_waw !== 1'b0) begin failures++; $display("FAIL sc_waw_end: got %0b expected 0", rsv_waw); end
  endtask

  task automatic test_reg0();
    apply_reset();
    alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 32'h0BAD0000;
    #1;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready: got %0b expected 1", alu_ready); end
    edge_wait();
    alu_valid = 1'b0;
    checks++; if (wr_en !== 1'b0 || wr_onehot !== 16'h0) begin failures++; $display("FAIL r0_no_write: got en=%0b oh=%04h expected 0/0000", wr_en, wr_onehot); end
    rsv_en = 1'b1; rsv_reg = 4'd0;
    edge_wait();
    rsv_en = 1'b0;
    checks++; if (busy !== 16'h0000 || rsv_waw !== 1'b0) begin failures++; $display("FAIL r0_rsv: got busy=%04h waw=%0b expected 0000/0", busy, rsv_waw); end
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'h11111111;
    mem_valid = 1'b1; mem_dest = 4'd2; mem_data = 32'h22222222;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin failures++; $display("FAIL r0_rr: got alu=%0b mem=%0b expected 0/1", alu_ready, mem_ready); end
    edge_wait();
    idle_inputs();
    checks++; if (wr_onehot !== 16'h0004 || wr_data !== 32'h22222222) begin failures++; $display("FAIL r0_mem_wr: got oh=%04h data=%08h expected 0004/22222222", wr_onehot, wr_data); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mem_valid = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      mem_dest = 4'(d); mem_data = 32'(d * 16'h1111);
      #1;
      checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %0b expected 1", d, mem_ready); end
      edge_wait();
      checks++; if (wr_onehot !== (16'h0001 << d)) begin failures++; $display("FAIL b2b_onehot_%0d: got %04h expected %04h", d, wr_onehot, 16'h0001 << d); end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit                m_last_mem;
    logic [15:0]       m_busy;
    bit                hold_alu, hold_mem;
    bit                exp_ga, exp_gm, exp_waw, x;
    logic [3:0]        d;
    logic [DATA_W-1:0] dat;
    logic [DATA_W+3:0] e;
    apply_reset();
    exp_q.delete();
    m_last_mem = 1'b1; m_busy = 16'h0; hold_alu = 1'b0; hold_mem = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_alu) begin
        alu_valid = ($urandom_range(0, 2) != 0); alu_dest = 4'($urandom_range(0, 15)); alu_data = $urandom;
      end
      if (!hold_mem) begin
        mem_valid = ($urandom_range(0, 2) != 0); mem_dest = 4'($urandom_range(0, 15)); mem_data = $urandom;
      end
      rsv_en = ($urandom_range(0, 2) == 0); rsv_reg = 4'($urandom_range(0, 15));
      #1;
      // round robin: a lone requester wins; a contest goes to whoever did not win last
      if (alu_valid && mem_valid) begin
        exp_ga = m_last_mem; exp_gm = !m_last_mem;
      end else begin
        exp_ga = alu_valid; exp_gm = mem_valid;
      end
      checks++; if (alu_ready !== exp_ga || mem_ready !== exp_gm) begin failures++; $display("FAIL rnd_grant_%0d: got alu=%0b mem=%0b expected %0b/%0b", c, alu_ready, mem_ready, exp_ga, exp_gm); end
      x = exp_ga || exp_gm;
      d = exp_ga ? alu_dest : mem_dest;
      dat = exp_ga ? alu_data : mem_data;
      if (x && d != 4'd0) exp_q.push_back({d, dat});
      exp_waw = rsv_en && (rsv_reg != 4'd0) && m_busy[rsv_reg] && !(x && d == rsv_reg);
      if (x) m_busy[d] = 1'b0;
      if (rsv_en && rsv_reg != 4'd0) m_busy[rsv_reg] = 1'b1;
      if (x) m_last_mem = exp_gm;
      hold_alu = alu_valid && !exp_ga;
      hold_mem = mem_valid && !exp_gm;
      edge_wait();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (wr_en !== 1'b1 || wr_reg !== e[DATA_W+3:DATA_W] || wr_data !== e[DATA_W-1:0] || wr_onehot !== (16'h0001 << e[DATA_W+3:DATA_W])) begin
          failures++; $display("FAIL rnd_write_%0d: got en=%0b reg=%0d data=%08h oh=%04h expected 1/%0d/%08h", c, wr_en, wr_reg, wr_data, wr_onehot, e[DATA_W+3:DATA_W], e[DATA_W-1:0]);
        end
      end else begin
        checks++; if (wr_en !== 1'b0 || wr_onehot !== 16'h0) begin failures++; $display("FAIL rnd_nowrite_%0d: got en=%0b oh=%04h expected 0/0000", c, wr_en, wr_onehot); end
      end
      checks++; if (busy !== m_busy || rsv_waw !== exp_waw) begin failures++; $display("FAIL rnd_sb_%0d: got busy=%04h waw=%0b expected %04h/%0b", c, busy, rsv_waw, m_busy, exp_waw); end
    end
    idle_inputs();
  endtask

  // test sequence and final report
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_arbitration();
    test_scoreboard();
    test_set_clear_same_edge();
    test_reg0();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
